// File: rtl/draw_ctrl.sv
// draw_ctrl: sequences X load, Y/colour load and a SIDE*SIDE pixel draw for the square datapath
// Ports: clk, r_set (async active-low reset), ld_x/ld_yc/go (held-button requests),
//        en_x/en_y/en_c (register loads), en_ix/plot/busy (draw strobes), done (end pulse),
//        pix_cnt (index of the pixel being plotted)
module draw_ctrl #(
    parameter int SIDE = 4,
    parameter int CW   = 4
) (
    input  logic          clk,
    input  logic          r_set,
    input  logic          ld_x,
    input  logic          ld_yc,
    input  logic          go,
    output logic          en_x,
    output logic          en_y,
    output logic          en_c,
    output logic          en_ix,
    output logic          plot,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] pix_cnt
);
    localparam int PIX = SIDE * SIDE;
    typedef enum logic [2:0] {
        S_WAIT_X, S_LOAD_X, S_WAIT_YC, S_LOAD_YC, S_WAIT_GO, S_DRAW, S_DONE
    } state_t;
    state_t state, nxt;
    logic [CW-1:0] nxt_cnt;
    logic last;
    assign last = pix_cnt == CW'(PIX - 1);
    always_comb begin
        nxt = state;
        case (state)
            S_WAIT_X:  nxt = ld_x ? S_LOAD_X : S_WAIT_X;
            S_LOAD_X:  nxt = ld_x ? S_LOAD_X : S_WAIT_YC;
            S_WAIT_YC: nxt = ld_x ? S_LOAD_X : ld_yc ? S_LOAD_YC : S_WAIT_YC;
            S_LOAD_YC: nxt = ld_yc ? S_LOAD_YC : S_WAIT_GO;
            S_WAIT_GO: nxt = ld_x ? S_LOAD_X : ld_yc ? S_LOAD_YC : go ? S_DRAW : S_WAIT_GO;
            S_DRAW:    nxt = last ? S_DONE : S_DRAW;
            default:   nxt = S_WAIT_X;
        endcase
        nxt_cnt = (state == S_DRAW && !last) ? pix_cnt + 1'b1 : '0;
    end
    // outputs are registered from the next state so they line up with the state they belong to
    always_ff @(posedge clk or negedge r_set) begin
        if (!r_set) begin
            state   <= S_WAIT_X;
            pix_cnt <= '0;
            en_x    <= 1'b0;
            en_y    <= 1'b0;
            en_c    <= 1'b0;
            en_ix   <= 1'b0;
            plot    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= nxt;
            pix_cnt <= nxt_cnt;
            en_x    <= nxt == S_LOAD_X;
            en_y    <= nxt == S_LOAD_YC;
            en_c    <= nxt == S_LOAD_YC;
            en_ix   <= nxt == S_DRAW;
            plot    <= nxt == S_DRAW;
            busy    <= nxt == S_DRAW;
            done    <= nxt == S_DONE;
        end
    end
endmodule

// File: tb/tb_draw_ctrl.sv
// tb_draw_ctrl: table, directed and random checks of draw_ctrl at SIDE=4 and SIDE=2
module tb_draw_ctrl;
    logic clk = 0, r_set = 1, ld_x = 0, ld_yc = 0, go = 0;
    logic a_en_x, a_en_y, a_en_c, a_en_ix, a_plot, a_busy, a_done;
    logic b_en_x, b_en_y, b_en_c, b_en_ix, b_plot, b_busy, b_done;
    logic [3:0] a_pix;
    logic [1:0] b_pix;
    logic [10:0] out_a, out_b;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    draw_ctrl #(.SIDE(4), .CW(4)) dut_a (
        .clk(clk), .r_set(r_set), .ld_x(ld_x), .ld_yc(ld_yc), .go(go),
        .en_x(a_en_x), .en_y(a_en_y), .en_c(a_en_c), .en_ix(a_en_ix),
        .plot(a_plot), .busy(a_busy), .done(a_done), .pix_cnt(a_pix)
    );
    draw_ctrl #(.SIDE(2), .CW(2)) dut_b (
        .clk(clk), .r_set(r_set), .ld_x(ld_x), .ld_yc(ld_yc), .go(go),
        .en_x(b_en_x), .en_y(b_en_y), .en_c(b_en_c), .en_ix(b_en_ix),
        .plot(b_plot), .busy(b_busy), .done(b_done), .pix_cnt(b_pix)
    );

    assign out_a = {a_en_x, a_en_y, a_en_c, a_en_ix, a_plot, a_busy, a_done, a_pix};
    assign out_b = {b_en_x, b_en_y, b_en_c, b_en_ix, b_plot, b_busy, b_done, 2'b00, b_pix};

    // reference: which load is in progress, how far through the three-step setup we are,
    // how many pixels remain, and whether the end pulse is due
    typedef struct {
        bit ldx;
        bit ldyc;
        int stage;
        int left;
        bit fin;
    } model_t;

    model_t ma, mb;

    function automatic model_t step(model_t m, bit lx, bit ly, bit g, int pix);
        model_t n = m;
        if (m.left > 0) begin
            n.left = m.left - 1;
            n.fin = (n.left == 0);
        end else if (m.fin) begin
            n.fin = 0;
            n.stage = 0;
        end else if (m.ldx) begin
            n.ldx = lx;
            if (!lx) n.stage = 1;
        end else if (m.ldyc) begin
            n.ldyc = ly;
            if (!ly) n.stage = 2;
        end else if (lx) n.ldx = 1;
        else if (ly && m.stage >= 1) n.ldyc = 1;
        else if (g && m.stage == 2) n.left = pix;
        return n;
    endfunction

    function automatic logic [10:0] expv(model_t m, int pix);
        logic d = m.left > 0;
        return {m.ldx, m.ldyc, m.ldyc, d, d, d, m.fin, 4'(d ? pix - m.left : 0)};
    endfunction

    function automatic logic [10:0] mk(bit ex, bit eyc, bit pl, bit dn, int p);
        return {ex, eyc, eyc, pl, pl, pl, dn, 4'(p)};
    endfunction

    task automatic chk(string name, logic [10:0] got, logic [10:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic cyc(bit lx, bit ly, bit g);
        ld_x = lx;
        ld_yc = ly;
        go = g;
        @(posedge clk);
        ma = step(ma, lx, ly, g, 16);
        mb = step(mb, lx, ly, g, 4);
        @(negedge clk);
        chk("model_a", out_a, expv(ma, 16));
        chk("model_b", out_b, expv(mb, 4));
    endtask

    task automatic do_reset();
        ld_x = 0;
        ld_yc = 0;
        go = 0;
        #2 r_set = 0;
        #1;
        chk("async_reset_a", out_a, '0);
        chk("async_reset_b", out_b, '0);
        ma = '{default: 0};
        mb = '{default: 0};
        @(posedge clk);
        @(negedge clk);
        r_set = 1;
        chk("reset_hold_a", out_a, '0);
    endtask

    task automatic load_all();
        cyc(1, 0, 0);
        cyc(0, 0, 0);
        cyc(0, 1, 0);
        cyc(0, 0, 0);
    endtask

    typedef struct {
        bit lx;
        bit ly;
        bit g;
        logic [10:0] exp;
    } vec_t;

    vec_t tbl[$];

    initial begin
        int pa, pb, da, db, da_at, db_at, loads;
        repeat (3) tbl.push_back('{1, 0, 0, mk(1, 0, 0, 0, 0)});
        tbl.push_back('{0, 0, 0, mk(0, 0, 0, 0, 0)});
        repeat (2) tbl.push_back('{0, 1, 0, mk(0, 1, 0, 0, 0)});
        tbl.push_back('{0, 0, 0, mk(0, 0, 0, 0, 0)});
        tbl.push_back('{0, 0, 1, mk(0, 0, 1, 0, 0)});
        for (int p = 1; p < 16; p++) tbl.push_back('{0, 0, 0, mk(0, 0, 1, 0, p)});
        tbl.push_back('{0, 0, 0, mk(0, 0, 0, 1, 0)});
        tbl.push_back('{0, 0, 0, mk(0, 0, 0, 0, 0)});

        @(negedge clk);
        do_reset();

        // full sequence from the table
        foreach (tbl[i]) begin
            cyc(tbl[i].lx, tbl[i].ly, tbl[i].g);
            chk("table", out_a, tbl[i].exp);
        end

        // reset in the middle of a draw at pix_cnt 7
        load_all();
        cyc(0, 0, 1);
        repeat (7) cyc(0, 0, 0);
        chk("pre_reset_pix7", out_a, mk(0, 0, 1, 0, 7));
        do_reset();
        repeat (3) cyc(0, 1, 1);
        chk("needs_ld_x", out_a, '0);

        // go held for 40 cycles draws once
        load_all();
        pa = 0; pb = 0; da = 0; db = 0; da_at = 0; db_at = 0;
        for (int i = 1; i <= 40; i++) begin
            cyc(0, 0, 1);
            pa += int'(a_plot);
            pb += int'(b_plot);
            if (a_done) begin da++; da_at = i; end
            if (b_done) begin db++; db_at = i; end
        end
        chk("held_plots_a", 11'(pa), 11'd16);
        chk("held_dones_a", 11'(da), 11'd1);
        chk("held_plots_b", 11'(pb), 11'd4);
        chk("held_dones_b", 11'(db), 11'd1);
        chk("done_time_a", 11'(da_at), 11'd17);
        chk("done_time_b", 11'(db_at), 11'd5);

        // simultaneous requests in WAIT_GO: X reload wins
        load_all();
        cyc(1, 1, 1);
        chk("priority", 11'({a_en_x, a_plot}), 11'b10);
        cyc(0, 0, 0);

        // loads ignored while drawing
        load_all();
        cyc(0, 0, 1);
        pa = int'(a_plot);
        loads = 0;
        for (int i = 0; i < 15; i++) begin
            cyc(i[0], i[1], 0);
            pa += int'(a_plot);
            loads += int'(a_en_x | a_en_y | a_en_c);
        end
        cyc(0, 0, 0);
        chk("ignored_loads", 11'(loads), 11'd0);
        chk("ignored_len", 11'(pa), 11'd16);
        chk("ignored_done", 11'(a_done), 11'd1);
        do_reset();

        // random requests with occasional resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            else cyc($urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/draw_ctrl.md
# draw_ctrl

Control FSM that sequences the 4x4 square-drawing datapath for the VGA lab. It turns three user-level (held-button) requests into single-purpose enable strobes: load X, load Y plus colour, then draw. It issues exactly SIDE*SIDE plot cycles with `en_ix` asserted, then returns to await a new X. It sits between the debounced KEY/SW inputs and the datapath/VGA adapter.

## Interface

Parameters:
- `SIDE`, default 4: square edge length in pixels. Pixel count is `PIX = SIDE*SIDE`.
- `CW`, default 4: width of the pixel counter. Must satisfy `2**CW >= PIX`.

Ports:
- `clk`, in, 1: system clock. All state changes on its rising edge.
- `r_set`, in, 1: reset. Asynchronous, active-low.
- `ld_x`, in, 1: active-high level request to load X (held button).
- `ld_yc`, in, 1: active-high level request to load Y and colour.
- `go`, in, 1: active-high level request to start drawing.
- `en_x`, out, 1: datapath X-register load enable.
- `en_y`, out, 1: datapath Y-register load enable.
- `en_c`, out, 1: datapath colour-register load enable.
- `en_ix`, out, 1: datapath pixel-offset advance enable.
- `plot`, out, 1: VGA adapter write enable.
- `busy`, out, 1: high while drawing.
- `done`, out, 1: one-cycle pulse after the last pixel.
- `pix_cnt`, out, CW: index of the pixel currently being plotted.

## Operation

- Moore FSM. All outputs decode from the state register and `pix_cnt` register only; no input reaches an output combinationally.
- States and transitions:
  - `S_WAIT_X`: all enables low. `ld_x=1` -> `S_LOAD_X`.
  - `S_LOAD_X`: `en_x=1`. Stay while `ld_x=1`. `ld_x=0` -> `S_WAIT_YC`.
  - `S_WAIT_YC`: `ld_x=1` -> `S_LOAD_X` (re-load X). Otherwise `ld_yc=1` -> `S_LOAD_YC`.
  - `S_LOAD_YC`: `en_y=1`, `en_c=1`. Stay while `ld_yc=1`. Release -> `S_WAIT_GO`.
  - `S_WAIT_GO`: priority order `ld_x` -> `S_LOAD_X`, then `ld_yc` -> `S_LOAD_YC`, then `go` -> `S_DRAW`.
  - `S_DRAW`: `en_ix=1`, `plot=1`, `busy=1`. `pix_cnt` increments each cycle. When `pix_cnt==PIX-1`: clear `pix_cnt` to 0 and go to `S_DONE`. All inputs are ignored.
  - `S_DONE`: `done=1` for one cycle, then `S_WAIT_X` unconditionally.
- Holding `go` through `S_DONE` does not retrigger a draw; a new X load is required.
- Multiple requests high in the same cycle are resolved by the per-state priority above. Requests not listed for the current state are ignored.
- Reset (`r_set=0`), at any time including mid-draw:
  - state = `S_WAIT_X`, `pix_cnt=0`.
  - All outputs 0 immediately, without waiting for a clock edge.
- Counter arithmetic: unsigned, CW bits. Wrap occurs only via the explicit clear at `PIX-1`, never by overflow.

## Timing

- Load enables stay high for every cycle the corresponding request is held, including the first cycle after the state is entered. Repeated loads of the same value are harmless.
- Request sampled high at edge t: the enable is high from t through the edge after release.
- `go` sampled high at edge t (in `S_WAIT_GO`):
  - `plot`/`en_ix`/`busy` high for cycles t+1 .. t+PIX.
  - `pix_cnt` = 0 .. PIX-1 over those cycles.
  - `done` high in cycle t+PIX+1.
  - `S_WAIT_X` from t+PIX+2.
- Latency from `go` to first plot: 1 cycle. A draw occupies exactly PIX cycles with no gaps.
- Reset deassertion: first state change at the first rising `clk` edge after `r_set` goes high.

## Test plan

- **Reset:** assert `r_set=0` mid-`S_DRAW` at `pix_cnt=7` -> `plot`, `en_ix`, `busy`, `pix_cnt` all 0 before the next edge. After release, `ld_x` is required before anything else happens.
- **Full sequence:** `ld_x` high 3 cycles, `ld_yc` high 2 cycles, `go` high 1 cycle -> `en_x` high 3 cycles, `en_y`/`en_c` high 2 cycles, `plot` high exactly 16 consecutive cycles with `pix_cnt` 0..15, one `done` pulse, return to `S_WAIT_X`.
- **Held go:** `go` held for 40 cycles after loads -> exactly 16 plot cycles and one `done`. No second draw occurs.
- **Priority:** in `S_WAIT_GO`, `ld_x`, `ld_yc` and `go` rise together -> `en_x=1` next cycle, `plot` stays 0.
- **Inputs ignored while drawing:** toggle `ld_x`/`ld_yc` during `S_DRAW` -> no `en_x`/`en_y`/`en_c` assertion, draw length unchanged at 16.
- **Parameterisation:** `SIDE=2`, `CW=2` -> 4 plot cycles, `pix_cnt` 0..3, `done` at go+5.
